// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM read-modify-write controller.
package sram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 7;
    localparam int NB             = DATA_WIDTH_DEF / 8;
    localparam logic [NB-1:0] BE_FULL = {NB{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } state_e;

endpackage

// File: rtl/sram_byte_merge.sv
// Per-byte-lane merge of store data over the word read back from the macro.
module sram_byte_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int NB         = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] new_i,
    input  logic [NB-1:0]         be_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Request-side controller for a single-port SRAM macro without a write mask;
// partial stores run as read, merge, write-back.
//   state  | meaning
//   IDLE   | ready; loads/full stores/empty stores issued straight from req_*
//   RD     | load read in flight; capture dout into rsp_rdata_o
//   RMW_RD | partial store read in flight; merge store bytes over dout
//   RMW_WR | write merged word back; respond
module sram_rmw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NB_L       = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NB_L-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    state_e                state_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB_L-1:0]       be_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [DATA_WIDTH-1:0] merged;

    logic accept;
    logic be_full;
    logic be_none;
    logic csb_c;
    logic web_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] din_c;

    assign be_full     = &req_be_i;
    assign be_none     = ~|req_be_i;
    assign req_ready_o = reset_n && (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    sram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .NB         (NB_L)
    ) u_merge (
        .old_i    (sram_dout_i),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // Pins are driven from req_* in IDLE so the macro samples on the accepting edge.
    always_comb begin
        csb_c  = 1'b1;
        web_c  = 1'b1;
        addr_c = addr_q;
        din_c  = merged_q;
        case (state_q)
            IDLE: begin
                addr_c = req_addr_i;
                din_c  = req_wdata_i;
                if (accept) begin
                    if (!req_we_i) begin
                        csb_c = 1'b0;
                    end else if (be_full) begin
                        csb_c = 1'b0;
                        web_c = 1'b0;
                    end else if (!be_none) begin
                        csb_c = 1'b0;
                    end
                end
            end
            RMW_WR: begin
                csb_c = 1'b0;
                web_c = 1'b0;
            end
            default: begin
                csb_c = 1'b1;
            end
        endcase
    end

    assign sram_csb_o  = csb_c | ~reset_n;
    assign sram_web_o  = web_c;
    assign sram_addr_o = addr_c;
    assign sram_din_o  = din_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            merged_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!req_we_i) begin
                            state_q <= RD;
                        end else if (be_full || be_none) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            addr_q  <= req_addr_i;
                            wdata_q <= req_wdata_i;
                            be_q    <= req_be_i;
                            state_q <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata_q <= sram_dout_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                RMW_RD: begin
                    merged_q <= merged;
                    state_q  <= RMW_WR;
                end
                RMW_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Bench for sram_rmw_ctrl with a behavioural single-port macro and a word-array reference.
module tb_sram_rmw_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [6:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        sram_csb_o;
    logic        sram_web_o;
    logic [6:0]  sram_addr_o;
    logic [31:0] sram_din_o;
    logic [31:0] sram_dout_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic        csb_l, web_l;
    logic [6:0]  addr_l;
    logic [31:0] din_l;
    int          csb_low_cnt = 0;
    int          rsp_cnt     = 0;

    sram_rmw_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .sram_csb_o  (sram_csb_o),
        .sram_web_o  (sram_web_o),
        .sram_addr_o (sram_addr_o),
        .sram_din_o  (sram_din_o),
        .sram_dout_i (sram_dout_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: inputs sampled at posedge, dout invalid until the negedge, writes commit at negedge.
    always @(posedge clock or negedge clock) begin
        if (clock) begin
            csb_l  <= sram_csb_o;
            web_l  <= sram_web_o;
            addr_l <= sram_addr_o;
            din_l  <= sram_din_o;
            if (!sram_csb_o) sram_dout_i <= 'x;
        end else if (!csb_l) begin
            if (!web_l) mem[addr_l] <= din_l;
            else        sram_dout_i <= mem[addr_l];
        end
    end

    always @(posedge clock) if (!sram_csb_o) csb_low_cnt <= csb_low_cnt + 1;
    always @(negedge clock) if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic void ref_store(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    // Edges from acceptance to the response being visible.
    function automatic int exp_lat(input logic we, input logic [3:0] be);
        if (!we) return 2;
        if (be == 4'h0 || be == 4'hF) return 1;
        return 3;
    endfunction

    task automatic do_req(input logic we, input logic [6:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int lat, output logic [31:0] rd, output int rdy_low);
        logic acc;
        @(negedge clock);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready_o) acc = 1'b1;
            @(posedge clock);
            if (acc) break;
            @(negedge clock);
        end
        #1 req_valid_i = 1'b0;
        lat = -1;
        rd = '0;
        rdy_low = 0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_timeout: addr=%0d accepted=%0b required=1", a, acc);
            return;
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (rsp_valid_o) begin
                lat = k;
                rd = rsp_rdata_o;
                break;
            end
            if (!req_ready_o) rdy_low++;
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 7'd3;
        req_wdata_i = '0;
        req_be_i    = 4'hF;
        repeat (3) @(negedge clock);
        total++;
        if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got=%b exp=0", rsp_valid_o); end
        total++;
        if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got=%h exp=0", rsp_rdata_o); end
        total++;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b exp=0", req_ready_o); end
        total++;
        if (sram_csb_o !== 1'b1) begin bad++; $display("FAIL reset_csb: got=%b exp=1", sram_csb_o); end
        req_valid_i = 1'b0;
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got=%b exp=1", req_ready_o); end
    endtask

    task automatic test_fill();
        int lat, rl;
        logic [31:0] rd, d;
        int errs = 0;
        for (int a = 0; a < 128; a++) begin
            d = $urandom;
            do_req(1'b1, 7'(a), d, 4'hF, lat, rd, rl);
            ref_store(7'(a), d, 4'hF);
            if (lat != 1) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL fill_latency: wrong_latency_count=%0d exp=0", errs); end
    endtask

    task automatic test_full_store_load();
        int lat, rl;
        logic [31:0] rd;
        do_req(1'b1, 7'd5, 32'hDEADBEEF, 4'hF, lat, rd, rl);
        ref_store(7'd5, 32'hDEADBEEF, 4'hF);
        total++;
        if (lat != 1) begin bad++; $display("FAIL full_store_lat: got=%0d exp=1", lat); end
        do_req(1'b0, 7'd5, 32'h0, 4'h0, lat, rd, rl);
        total++;
        if (lat != 2) begin bad++; $display("FAIL load_lat: got=%0d exp=2", lat); end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata: got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_partial_store();
        int lat, rl;
        logic [31:0] rd;
        do_req(1'b1, 7'd9, 32'h11223344, 4'hF, lat, rd, rl);
        ref_store(7'd9, 32'h11223344, 4'hF);
        do_req(1'b1, 7'd9, 32'hAABBCCDD, 4'b0101, lat, rd, rl);
        ref_store(7'd9, 32'hAABBCCDD, 4'b0101);
        total++;
        if (lat != 3) begin bad++; $display("FAIL partial_lat: got=%0d exp=3", lat); end
        total++;
        if (rl != 2) begin bad++; $display("FAIL partial_ready_low: got=%0d exp=2", rl); end
        do_req(1'b0, 7'd9, 32'h0, 4'h0, lat, rd, rl);
        total++;
        if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL partial_rdata: got=%h exp=11bb33dd", rd); end
        total++;
        if (rd !== ref_mem[9]) begin bad++; $display("FAIL partial_ref: got=%h exp=%h", rd, ref_mem[9]); end
    endtask

    task automatic test_back_to_back();
        int lat, rl;
        logic [31:0] rd;
        logic [31:0] d [4];
        int pulses = 0;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        @(negedge clock);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_be_i    = 4'hF;
        req_addr_i  = 7'd0;
        req_wdata_i = d[0];
        for (int i = 0; i < 4; i++) begin
            if (!req_ready_o) begin
                total++; bad++;
                $display("FAIL b2b_ready: idx=%0d got=0 exp=1", i);
            end
            @(posedge clock);
            ref_store(7'(i), d[i], 4'hF);
            @(negedge clock);
            if (rsp_valid_o) pulses++;
            if (i < 3) begin
                req_addr_i  = 7'(i + 1);
                req_wdata_i = d[i + 1];
            end else begin
                req_valid_i = 1'b0;
            end
        end
        total++;
        if (pulses != 4) begin bad++; $display("FAIL b2b_pulses: got=%0d exp=4", pulses); end
        @(negedge clock);
        total++;
        if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_rsp_end: got=%b exp=0", rsp_valid_o); end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 7'(i), 32'h0, 4'h0, lat, rd, rl);
            total++;
            if (rd !== d[i]) begin bad++; $display("FAIL b2b_readback: addr=%0d got=%h exp=%h", i, rd, d[i]); end
        end
    endtask

    task automatic test_be_zero();
        int lat, rl, c0;
        logic [31:0] rd;
        do_req(1'b1, 7'd7, 32'h12345678, 4'hF, lat, rd, rl);
        ref_store(7'd7, 32'h12345678, 4'hF);
        c0 = csb_low_cnt;
        do_req(1'b1, 7'd7, 32'hCAFEF00D, 4'h0, lat, rd, rl);
        @(negedge clock);
        total++;
        if (lat != 1) begin bad++; $display("FAIL be0_lat: got=%0d exp=1", lat); end
        total++;
        if (csb_low_cnt != c0) begin bad++; $display("FAIL be0_csb: accesses=%0d exp=0", csb_low_cnt - c0); end
        total++;
        if (mem[7] !== 32'h12345678) begin bad++; $display("FAIL be0_mem: got=%h exp=12345678", mem[7]); end
    endtask

    task automatic test_reset_mid_rmw();
        int r0;
        @(negedge clock);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 7'd2;
        req_wdata_i = ~ref_mem[2];
        req_be_i    = 4'b0011;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rmw_rst_ready_pre: got=%b exp=1", req_ready_o); end
        @(posedge clock);
        #1 req_valid_i = 1'b0;
        @(negedge clock);
        r0 = rsp_cnt;
        reset_n = 1'b0;
        #1;
        total++;
        if (req_ready_o !== 1'b0 || sram_csb_o !== 1'b1) begin
            bad++;
            $display("FAIL rmw_rst_pins: ready=%b csb=%b exp ready=0 csb=1", req_ready_o, sram_csb_o);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL rmw_rst_ready_post: got=%b exp=1", req_ready_o); end
        repeat (4) @(negedge clock);
        #1;
        total++;
        if (rsp_cnt != r0) begin bad++; $display("FAIL rmw_rst_rsp: pulses=%0d exp=0", rsp_cnt - r0); end
        total++;
        if (mem[2] !== ref_mem[2]) begin bad++; $display("FAIL rmw_rst_mem: got=%h exp=%h", mem[2], ref_mem[2]); end
    endtask

    task automatic test_load_pair();
        @(negedge clock);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_be_i    = 4'h0;
        req_addr_i  = 7'd127;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL pair_ready0: got=%b exp=1", req_ready_o); end
        @(posedge clock);
        #1 req_addr_i = 7'd0;
        @(negedge clock);
        total++;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL pair_ready1: got=%b exp=0", req_ready_o); end
        @(negedge clock);
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL pair_ready2: got=%b exp=1", req_ready_o); end
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== ref_mem[127]) begin
            bad++;
            $display("FAIL pair_rsp127: valid=%b data=%h exp valid=1 data=%h", rsp_valid_o, rsp_rdata_o, ref_mem[127]);
        end
        @(posedge clock);
        #1 req_valid_i = 1'b0;
        @(negedge clock);
        total++;
        if (req_ready_o !== 1'b0) begin bad++; $display("FAIL pair_ready3: got=%b exp=0", req_ready_o); end
        @(negedge clock);
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== ref_mem[0]) begin
            bad++;
            $display("FAIL pair_rsp0: valid=%b data=%h exp valid=1 data=%h", rsp_valid_o, rsp_rdata_o, ref_mem[0]);
        end
    endtask

    task automatic test_random();
        int lat, rl;
        logic [31:0] rd, d, exp_rd;
        logic [6:0] a;
        logic [3:0] be;
        logic we;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            d  = $urandom;
            case ($urandom_range(0, 5))
                0:       be = 4'h0;
                1:       be = 4'hF;
                default: be = 4'($urandom_range(0, 15));
            endcase
            exp_rd = ref_mem[a];
            do_req(we, a, d, be, lat, rd, rl);
            if (we) ref_store(a, d, be);
            total++;
            if (lat != exp_lat(we, be)) begin
                bad++;
                $display("FAIL rand_lat: n=%0d we=%b be=%h got=%0d exp=%0d", n, we, be, lat, exp_lat(we, be));
            end
            total++;
            if (rl != exp_lat(we, be) - 1) begin
                bad++;
                $display("FAIL rand_ready_low: n=%0d got=%0d exp=%0d", n, rl, exp_lat(we, be) - 1);
            end
            if (!we) begin
                total++;
                if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata: n=%0d addr=%0d got=%h exp=%h", n, a, rd, exp_rd); end
            end
            @(negedge clock);
            total++;
            if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rand_pulse_width: n=%0d got=%b exp=0", n, rsp_valid_o); end
        end
    endtask

    task automatic test_mem_final();
        int errs = 0;
        for (int a = 0; a < 128; a++)
            if (mem[a] !== ref_mem[a]) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL mem_final: differing_words=%0d exp=0", errs); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_store_load();
        test_partial_store();
        test_back_to_back();
        test_be_zero();
        test_reset_mid_rmw();
        test_load_pair();
        test_random();
        test_mem_final();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
